tag_dcache: RTL and testbench

- Tag/lookup stage of the pipelined 2-way set-associative data cache; sits directly upstream of the data-array (memory) stage.
- Registers the CPU request and owns the tag, valid, dirty and LRU state.
- Produces hit, hit-way and LRU information for the data stage.
- Runs the miss state machine (dirty-victim writeback, line fetch) against physical memory and stalls the pipeline until the line is resident.

---
 rtl/tag_dcache_if.sv | 36 +++
 rtl/tag_dcache.sv | 156 +++++++++++++++
 tb/tb_tag_dcache.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tag_dcache_if.sv
// rtl/tag_dcache_if.sv - request, stage-output and memory bus of the cache tag stage
interface tag_dcache_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_en;
    logic        stage_stall;
    logic        out_valid;
    logic        out_read;
    logic        out_write;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_byte_en;
    logic        out_hit;
    logic        out_way;
    logic        out_lru;
    logic        stall_out;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic        pmem_resp;
    logic        fill_valid;

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_byte_en, stage_stall, pmem_resp,
        input  out_valid, out_read, out_write, out_addr, out_wdata, out_byte_en, out_hit,
               out_way, out_lru, stall_out, pmem_read, pmem_write, pmem_addr, fill_valid
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_byte_en, stage_stall, pmem_resp,
        output out_valid, out_read, out_write, out_addr, out_wdata, out_byte_en, out_hit,
               out_way, out_lru, stall_out, pmem_read, pmem_write, pmem_addr, fill_valid
    );
endinterface

// File: rtl/tag_dcache.sv
// rtl/tag_dcache.sv - tag/lookup stage and miss FSM of a 2-way set-associative data cache
module tag_dcache #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int num_sets = 2 ** s_index
) (
    input logic         clk,
    input logic         rst_n,
    tag_dcache_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t              state;
    logic [num_sets-1:0] valid0, valid1, dirty0, dirty1, lru;
    logic [s_tag-1:0]    tag0 [num_sets];
    logic [s_tag-1:0]    tag1 [num_sets];
    logic                victim_q;

    logic                rvalid, rread, rwrite;
    logic [31:0]         raddr, rwdata;
    logic [3:0]          rbyte_en;
    logic                pread, pwrite;
    logic [31:0]         paddr;

    logic [s_index-1:0]  idx;
    logic [s_tag-1:0]    tag_in;
    logic [s_tag-1:0]    victim_tag;
    logic [31:0]         fetch_addr;
    logic                hit0, hit1, hit, miss, stall, advance;
    logic                victim_c, victim, victim_dirty;

    assign idx        = raddr[s_offset +: s_index];
    assign tag_in     = raddr[s_offset + s_index +: s_tag];
    assign hit0       = valid0[idx] & (tag0[idx] == tag_in);
    assign hit1       = valid1[idx] & (tag1[idx] == tag_in);
    assign hit        = rvalid & (hit0 | hit1);
    assign miss       = rvalid & ~(hit0 | hit1);

    // Fill an empty way first (way 0 before way 1); only evict when the set is full.
    assign victim_c     = ~valid0[idx] ? 1'b0 : (~valid1[idx] ? 1'b1 : lru[idx]);
    assign victim       = (state == IDLE) ? victim_c : victim_q;
    assign victim_dirty = victim_c ? (valid1[idx] & dirty1[idx]) : (valid0[idx] & dirty0[idx]);
    assign victim_tag   = victim_c ? tag1[idx] : tag0[idx];
    assign fetch_addr   = {raddr[31:s_offset], {s_offset{1'b0}}};

    assign stall   = bus.stage_stall | miss | (state != IDLE);
    assign advance = hit & ~bus.stage_stall & (state == IDLE);

    assign bus.out_valid   = rvalid;
    assign bus.out_read    = rread;
    assign bus.out_write   = rwrite;
    assign bus.out_addr    = raddr;
    assign bus.out_wdata   = rwdata;
    assign bus.out_byte_en = rbyte_en;
    assign bus.out_hit     = hit;
    assign bus.out_way     = hit ? hit1 : victim;
    assign bus.out_lru     = lru[idx];
    assign bus.stall_out   = stall;
    assign bus.pmem_read   = pread;
    assign bus.pmem_write  = pwrite;
    assign bus.pmem_addr   = paddr;
    assign bus.fill_valid  = (state == FETCH) & bus.pmem_resp;

    // Stage register: capture the CPU request whenever the pipeline is not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid   <= 1'b0;
            rread    <= 1'b0;
            rwrite   <= 1'b0;
            raddr    <= '0;
            rwdata   <= '0;
            rbyte_en <= '0;
        end else if (!stall) begin
            rvalid   <= bus.req_read | bus.req_write;
            rread    <= bus.req_read & ~bus.req_write;
            rwrite   <= bus.req_write;
            raddr    <= bus.req_addr;
            rwdata   <= bus.req_wdata;
            rbyte_en <= bus.req_byte_en;
        end
    end

    // Tag arrays need no reset: a tag is only trusted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == FETCH && bus.pmem_resp) begin
            if (victim_q) tag1[idx] <= tag_in;
            else          tag0[idx] <= tag_in;
        end
    end

    // Miss FSM plus valid/dirty/LRU bookkeeping; memory strobes are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid0   <= '0;
            valid1   <= '0;
            dirty0   <= '0;
            dirty1   <= '0;
            lru      <= '0;
            victim_q <= 1'b0;
            pread    <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
        end else begin
            if (advance) begin
                lru[idx] <= ~hit1;
                if (rwrite) begin
                    if (hit1) dirty1[idx] <= 1'b1;
                    else      dirty0[idx] <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (miss) begin
                        victim_q <= victim_c;
                        if (victim_dirty) begin
                            state  <= WRITEBACK;
                            pwrite <= 1'b1;
                            paddr  <= {victim_tag, idx, {s_offset{1'b0}}};
                        end else begin
                            state <= FETCH;
                            pread <= 1'b1;
                            paddr <= fetch_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state  <= FETCH;
                        pwrite <= 1'b0;
                        pread  <= 1'b1;
                        paddr  <= fetch_addr;
                        if (victim_q) dirty1[idx] <= 1'b0;
                        else          dirty0[idx] <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.pmem_resp) begin
                        state <= IDLE;
                        pread <= 1'b0;
                        paddr <= '0;
                        if (victim_q) begin
                            valid1[idx] <= 1'b1;
                            dirty1[idx] <= 1'b0;
                        end else begin
                            valid0[idx] <= 1'b1;
                            dirty0[idx] <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tag_dcache.sv
// tb/tb_tag_dcache.sv - randomized self-checking bench for tag_dcache against a set/way model
module tb_tag_dcache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_dcache_if bus();
    tag_dcache dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    bit [23:0] m_tag   [2][8];
    bit        m_valid [2][8];
    bit        m_dirty [2][8];
    bit        m_lru   [8];

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
                m_tag[w][s]   = '0;
            end
        for (int s = 0; s < 8; s++) m_lru[s] = 0;
    endtask

    // One request from issue to the cycle it advances; caller is at a negedge with stall_out=0.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input int lat, input int stall_cyc);
        int s;
        bit [23:0] t;
        bit hit, way, wb;
        logic [31:0] wb_addr, wdata;
        logic [3:0] ben;
        logic [6:0] exp_f, got_f;
        s = int'(addr[7:5]);
        t = addr[31:8];
        wdata = $urandom;
        ben = 4'($urandom_range(0, 15));
        bus.req_read = rd; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_byte_en = ben;
        @(negedge clk);
        bus.req_read = 0; bus.req_write = 0;
        hit = 0; way = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][s] && m_tag[w][s] == t) begin hit = 1; way = w[0]; end
        if (!hit) way = !m_valid[0][s] ? 1'b0 : (!m_valid[1][s] ? 1'b1 : m_lru[s]);
        exp_f = {1'b1, rd & ~wr, wr, hit, way, m_lru[s], ~hit};
        got_f = {bus.out_valid, bus.out_read, bus.out_write, bus.out_hit, bus.out_way, bus.out_lru, bus.stall_out};
        n_cmp++;
        if (got_f !== exp_f) begin n_fail++; $display("FAIL load_flags addr=%h got=%b expected=%b", addr, got_f, exp_f); end
        n_cmp++;
        if ({bus.out_addr, bus.out_wdata, bus.out_byte_en} !== {addr, wdata, ben}) begin
            n_fail++; $display("FAIL load_data got=%h/%h/%h expected=%h/%h/%h", bus.out_addr, bus.out_wdata, bus.out_byte_en, addr, wdata, ben);
        end
        if (!hit) begin
            wb = m_valid[way][s] && m_dirty[way][s];
            wb_addr = {m_tag[way][s], 3'(s), 5'b0};
            @(negedge clk);
            if (wb) begin
                n_cmp++;
                if ({bus.pmem_write, bus.pmem_read, bus.pmem_addr} !== {2'b10, wb_addr}) begin
                    n_fail++; $display("FAIL wb_start w/r=%b%b addr=%h expected 10 %h", bus.pmem_write, bus.pmem_read, bus.pmem_addr, wb_addr);
                end
                repeat (lat - 1) @(negedge clk);
                n_cmp++;
                if ({bus.pmem_write, bus.pmem_read, bus.pmem_addr} !== {2'b10, wb_addr}) begin
                    n_fail++; $display("FAIL wb_hold w/r=%b%b addr=%h expected 10 %h", bus.pmem_write, bus.pmem_read, bus.pmem_addr, wb_addr);
                end
                bus.pmem_resp = 1;
                @(negedge clk);
                bus.pmem_resp = 0;
                m_dirty[way][s] = 0;
            end
            n_cmp++;
            if ({bus.pmem_write, bus.pmem_read, bus.pmem_addr, bus.out_way, bus.stall_out} !== {2'b01, addr[31:5], 5'b0, way, 1'b1}) begin
                n_fail++; $display("FAIL fetch_start w/r=%b%b addr=%h way=%b stall=%b expected 01 %h way=%b", bus.pmem_write, bus.pmem_read, bus.pmem_addr, bus.out_way, bus.stall_out, {addr[31:5], 5'b0}, way);
            end
            repeat (lat - 1) @(negedge clk);
            bus.pmem_resp = 1;
            #1;
            n_cmp++;
            if ({bus.fill_valid, bus.out_way, bus.pmem_read, bus.out_hit} !== {1'b1, way, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL fill fill/way/read/hit=%b expected %b", {bus.fill_valid, bus.out_way, bus.pmem_read, bus.out_hit}, {1'b1, way, 1'b1, 1'b0});
            end
            @(negedge clk);
            bus.pmem_resp = 0;
            m_tag[way][s] = t; m_valid[way][s] = 1; m_dirty[way][s] = 0;
            n_cmp++;
            if ({bus.pmem_read, bus.pmem_write, bus.fill_valid, bus.out_hit, bus.out_way, bus.out_lru, bus.stall_out} !== {3'b000, 1'b1, way, m_lru[s], 1'b0}) begin
                n_fail++; $display("FAIL post_fill r/w/fill/hit/way/lru/stall=%b expected %b", {bus.pmem_read, bus.pmem_write, bus.fill_valid, bus.out_hit, bus.out_way, bus.out_lru, bus.stall_out}, {3'b000, 1'b1, way, m_lru[s], 1'b0});
            end
        end
        if (stall_cyc > 0) begin
            bus.stage_stall = 1;
            bus.req_read = 1;
            bus.req_addr = $urandom;
            repeat (stall_cyc) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.out_valid, bus.out_hit, bus.out_way, bus.out_lru, bus.stall_out, bus.out_addr} !== {1'b1, 1'b1, way, m_lru[s], 1'b1, addr}) begin
                    n_fail++; $display("FAIL stall_hold v/h/way/lru/stall=%b addr=%h expected %b %h", {bus.out_valid, bus.out_hit, bus.out_way, bus.out_lru, bus.stall_out}, bus.out_addr, {2'b11, way, m_lru[s], 1'b1}, addr);
                end
            end
            bus.stage_stall = 0;
            bus.req_read = 0;
        end
        m_lru[s] = ~way;
        if (wr) m_dirty[way][s] = 1;
    endtask

    task automatic test_reset();
        logic [140:0] got;
        bus.req_read = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_byte_en = '0; bus.stage_stall = 0; bus.pmem_resp = 0;
        rst_n = 0;
        model_clear();
        repeat (2) @(negedge clk);
        got = {bus.out_valid, bus.out_read, bus.out_write, bus.out_addr, bus.out_wdata, bus.out_byte_en, bus.out_hit, bus.out_way,
               bus.out_lru, bus.stall_out, bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.fill_valid};
        n_cmp++;
        if (got !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h expected 0", got); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_req(1, 0, 32'h0000_0040, 5, 0);
        do_req(1, 0, 32'h0000_0040, 5, 0);
        do_req(0, 1, 32'h0000_1040, 5, 0);
        do_req(1, 0, 32'h0000_2040, 5, 0);
        do_req(1, 0, 32'h0000_3040, 5, 0);
    endtask

    task automatic test_stage_stall();
        do_req(1, 0, 32'h0000_2044, 5, 3);
        do_req(0, 1, 32'h0000_3048, 5, 3);
        do_req(1, 0, 32'h0000_2040, 5, 0);
    endtask

    task automatic test_reset_mid_fetch();
        bus.req_read = 1; bus.req_addr = 32'h00AB_00E0;
        @(negedge clk);
        bus.req_read = 0;
        n_cmp++;
        if ({bus.out_hit, bus.stall_out} !== 2'b01) begin n_fail++; $display("FAIL rmf_miss hit/stall=%b%b expected 01", bus.out_hit, bus.stall_out); end
        @(negedge clk);
        n_cmp++;
        if ({bus.pmem_read, bus.pmem_addr} !== {1'b1, 32'h00AB_00E0}) begin n_fail++; $display("FAIL rmf_fetch read=%b addr=%h expected 1 00ab00e0", bus.pmem_read, bus.pmem_addr); end
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++;
        if ({bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.out_valid, bus.out_hit, bus.fill_valid, bus.stall_out} !== '0) begin
            n_fail++; $display("FAIL rmf_async_clear read=%b write=%b addr=%h valid=%b stall=%b expected all 0", bus.pmem_read, bus.pmem_write, bus.pmem_addr, bus.out_valid, bus.stall_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_clear();
        @(negedge clk);
        do_req(1, 0, 32'h0000_2040, 3, 0);
        do_req(1, 0, 32'h00AB_00E0, 2, 0);
        do_req(0, 1, 32'h0000_0040, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int op, stall_cyc;
        bit rd, wr;
        for (int i = 0; i < 60; i++) begin
            addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            op = $urandom_range(0, 3);
            rd = (op != 1); wr = (op == 1 || op == 2);
            stall_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_req(rd, wr, addr, $urandom_range(1, 6), stall_cyc);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.out_valid, bus.stall_out} !== 2'b00) begin n_fail++; $display("FAIL idle valid/stall=%b%b expected 00", bus.out_valid, bus.stall_out); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stage_stall();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
